eeprom_req_seq: RTL and testbench
=================================

// Module: eeprom_req_seq
// PURPOSE
//  Synthesizable host-side request sequencer for the EEPROM_WR I2C bridge.
//  - Issues RD/WR request pulses, addresses and data bursts to the bridge.
//  - Replaces the fixed 16-byte behavioural stimulus with parametrised widths, burst length and modes.
//  - Self-checks readback against a regenerated pattern; counts mismatches; detects missing ACKs.
// PARAMETERS
//  AW       11    address width
//  DW       8     data width
//  NW       8     burst-count width (max burst 2^NW-1 bytes)
//  GAP      5     idle CLK cycles before each request pulse (>=1)
//  PULSE    1     request pulse width in CLK cycles (>=1)
//  TMO      4096  max CLK cycles waiting for ACK before abort
// PORTS
//  CLK        in   1    clock
//  RESET      in   1    synchronous, active-high reset
//  START      in   1    1-cycle start; ignored unless BUSY=0
//  MODE       in   2    0=write, 1=read+check, 2=write then read+check, 3=reserved (treated as 0)
//  BASE_ADDR  in   AW   first address of burst
//  NUM        in   NW   bytes per burst; 0 -> immediate DONE, no requests
//  SEED       in   DW   pattern seed
//  WR         out  1    write request pulse to bridge
//  RD         out  1    read request pulse to bridge
//  ADDR       out  AW   request address
//  DATA_OUT   out  DW   write data
//  DATA_OE    out  1    1 while in a write phase (drives bidirectional DATA)
//  DATA_IN    in   DW   read data from bridge
//  ACK        in   1    bridge completion; rising edge ends a transfer
//  BUSY       out  1    sequence in progress
//  DONE       out  1    1-cycle pulse at end of sequence (normal or abort)
//  TIMEOUT    out  1    sticky: last sequence aborted on missing ACK
//  ERR_CNT    out  NW   readback mismatches in last sequence (saturating)
//  ERR_ADDR   out  AW   address of first mismatch (valid if ERR_CNT!=0)
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; ack_d=0.
//  - Pattern: exp(a) = a[DW-1:0] ^ SEED (a zero-extended if AW<DW).
//  - Address: BASE_ADDR+k mod 2^AW; wrap 2^AW-1 -> 0 is legal.
//  - ACK edge: ack_rise = ACK & ~ack_d; ack_d registered every cycle. Only ack_rise counts; a level held high does not.
//  - FSM: IDLE -> GAP -> REQ -> WAIT -> (CHK) -> GAP | SWITCH | FIN.
//    IDLE: START & MODE/NUM latched; BUSY=1 next cycle. NUM=0 -> FIN directly.
//      Phase = write unless MODE=1. Clear ERR_CNT, ERR_ADDR, TIMEOUT.
//    GAP: GAP cycles. ADDR/DATA_OUT valid from first GAP cycle and held through WAIT.
//    REQ: WR (write phase) or RD (read phase) high exactly PULSE cycles.
//    WAIT: counts cycles. ack_rise -> CHK (read) or NEXT (write).
//      Count reaching TMO -> TIMEOUT=1, FIN.
//      ack_rise during GAP/REQ is ignored.
//    CHK: DATA_IN sampled in the cycle ack_rise is seen.
//      Mismatch: ERR_CNT += 1, saturating at 2^NW-1. If first, ERR_ADDR=addr.
//    NEXT: k+1<NUM -> GAP. Else if MODE=2 and write phase -> SWITCH. Else FIN.
//    SWITCH: k=0, phase=read, DATA_OE=0; then GAP.
//    FIN: DONE=1 one cycle, BUSY=0 same cycle, -> IDLE.
//  - DATA_OE=1 from START acceptance to end of write phase; 0 otherwise.
//  - START while BUSY: ignored, no effect on sequence.
//  - RESET mid-sequence: immediate return to IDLE, request pulses drop same edge, no DONE.
//  - Min per-byte period: GAP+PULSE+1+bridge latency cycles.
// TESTING
//  1. MODE=0, BASE=0x000, NUM=16, SEED=0xA5, bridge model ACKs 20 cyc after WR ->
//     16 WR pulses, ADDR 0..15, DATA_OUT=a^0xA5, one DONE, ERR_CNT=0.
//  2. MODE=2, BASE=0x7FE, NUM=4, SEED=0x3C, memory model ->
//     writes 7FE,7FF,000,001 (wrap), then 4 RD, ERR_CNT=0, DONE after 8th ACK.
//  3. As 2 but model corrupts byte at 0x7FF ->
//     ERR_CNT=1, ERR_ADDR=0x7FF, TIMEOUT=0.
//  4. MODE=0, NUM=3, model never ACKs 2nd request ->
//     TMO cycles after 2nd pulse: TIMEOUT=1, DONE pulse, BUSY=0, no 3rd WR.
//  5. NUM=0 START -> DONE 2 cycles later, no RD/WR. START during BUSY -> ignored.
//     ACK held high across 2 requests -> 2nd completes only on a new rising edge.
//  6. RESET asserted mid-WAIT of MODE=2 ->
//     next cycle all outputs 0, no DONE. New START runs cleanly from BASE.

Source files
------------

// File: rtl/eeprom_req_seq_if.sv
// Host-side bus bundle for the EEPROM request sequencer: sequence control
// and status towards the host, request/data/ack towards the I2C bridge.
interface eeprom_req_seq_if #(
  parameter int AW = 11,
  parameter int DW = 8,
  parameter int NW = 8
);
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] base_addr;
  logic [NW-1:0] num;
  logic [DW-1:0] seed;
  logic          wr;
  logic          rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic          data_oe;
  logic [DW-1:0] data_in;
  logic          ack;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [NW-1:0] err_cnt;
  logic [AW-1:0] err_addr;

  // sequencer side
  modport master (
    input  start, mode, base_addr, num, seed, data_in, ack,
    output wr, rd, addr, data_out, data_oe, busy, done, timeout, err_cnt, err_addr
  );

  // host/bridge side
  modport slave (
    output start, mode, base_addr, num, seed, data_in, ack,
    input  wr, rd, addr, data_out, data_oe, busy, done, timeout, err_cnt, err_addr
  );
endinterface

// File: rtl/eeprom_req_seq.sv
// Request sequencer for the EEPROM_WR I2C bridge: issues write and/or read
// bursts of a seeded address pattern and checks the readback.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; parameters latched on acceptance
// S_GAP    | idle gap before a request, addr/data already presented
// S_REQ    | wr or rd pulse high
// S_WAIT   | waiting for ack rising edge; readback check and next-byte step
// S_SWITCH | write phase done, rewind to base address for the read phase
// S_FIN    | one-cycle done pulse, busy drops
module eeprom_req_seq #(
  parameter int AW    = 11,
  parameter int DW    = 8,
  parameter int NW    = 8,
  parameter int GAP   = 5,
  parameter int PULSE = 1,
  parameter int TMO   = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  eeprom_req_seq_if.master  bus_io
);

  localparam int MAXC = (TMO > GAP) ? ((TMO > PULSE) ? TMO : PULSE)
                                    : ((GAP > PULSE) ? GAP : PULSE);
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_REQ, S_WAIT, S_SWITCH, S_FIN
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [NW-1:0] k_q;
  logic [NW-1:0] num_q;
  logic [AW-1:0] base_q;
  logic [DW-1:0] seed_q;
  logic          two_phase_q;
  logic          rd_phase_q;
  logic          ack_prev_q;
  logic          wr_q, rd_q, oe_q, busy_q, done_q, to_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] dout_q;
  logic [NW-1:0] errc_q;
  logic [AW-1:0] erra_q;

  logic ack_rise;
  logic mism;
  logic last_byte;

  // expected byte for an address: low address bits xor seed
  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic [DW-1:0] s);
    return DW'(a) ^ s;
  endfunction

  assign ack_rise  = bus_io.ack & ~ack_prev_q;
  assign mism      = (bus_io.data_in != pattern(addr_q, seed_q));
  assign last_byte = (({1'b0, k_q} + (NW+1)'(1)) >= {1'b0, num_q});

  // sequencing FSM with registered request, data and status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      num_q       <= '0;
      base_q      <= '0;
      seed_q      <= '0;
      two_phase_q <= 1'b0;
      rd_phase_q  <= 1'b0;
      ack_prev_q  <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      to_q        <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      errc_q      <= '0;
      erra_q      <= '0;
    end else begin
      ack_prev_q <= bus_io.ack;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus_io.start) begin
            busy_q      <= 1'b1;
            two_phase_q <= (bus_io.mode == 2'd2);
            rd_phase_q  <= (bus_io.mode == 2'd1);
            oe_q        <= (bus_io.mode != 2'd1) && (bus_io.num != '0);
            num_q       <= bus_io.num;
            base_q      <= bus_io.base_addr;
            seed_q      <= bus_io.seed;
            k_q         <= '0;
            addr_q      <= bus_io.base_addr;
            dout_q      <= pattern(bus_io.base_addr, bus_io.seed);
            errc_q      <= '0;
            erra_q      <= '0;
            to_q        <= 1'b0;
            cnt_q       <= CW'(GAP - 1);
            state_q     <= (bus_io.num == '0) ? S_FIN : S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            wr_q    <= ~rd_phase_q;
            rd_q    <= rd_phase_q;
            cnt_q   <= CW'(PULSE - 1);
            state_q <= S_REQ;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_REQ: begin
          if (cnt_q == '0) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= CW'(TMO - 1);
            state_q <= S_WAIT;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_WAIT: begin
          if (ack_rise) begin
            if (rd_phase_q && mism) begin
              if (errc_q != {NW{1'b1}}) errc_q <= errc_q + NW'(1);
              if (errc_q == '0) erra_q <= addr_q;
            end
            if (!last_byte) begin
              k_q     <= k_q + NW'(1);
              addr_q  <= addr_q + AW'(1);
              dout_q  <= pattern(addr_q + AW'(1), seed_q);
              cnt_q   <= CW'(GAP - 1);
              state_q <= S_GAP;
            end else if (two_phase_q && !rd_phase_q) begin
              oe_q    <= 1'b0;
              state_q <= S_SWITCH;
            end else begin
              oe_q    <= 1'b0;
              state_q <= S_FIN;
            end
          end else if (cnt_q == '0) begin
            to_q    <= 1'b1;
            oe_q    <= 1'b0;
            state_q <= S_FIN;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_SWITCH: begin
          k_q        <= '0;
          rd_phase_q <= 1'b1;
          addr_q     <= base_q;
          dout_q     <= pattern(base_q, seed_q);
          cnt_q      <= CW'(GAP - 1);
          state_q    <= S_GAP;
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_io.wr       = wr_q;
  assign bus_io.rd       = rd_q;
  assign bus_io.addr     = addr_q;
  assign bus_io.data_out = dout_q;
  assign bus_io.data_oe  = oe_q;
  assign bus_io.busy     = busy_q;
  assign bus_io.done     = done_q;
  assign bus_io.timeout  = to_q;
  assign bus_io.err_cnt  = errc_q;
  assign bus_io.err_addr = erra_q;

endmodule

// File: tb/tb_eeprom_req_seq.sv
// Bench for eeprom_req_seq: a behavioural bridge with memory, a request
// monitor, and an expected-transaction model built from the address/pattern rules.
module tb_eeprom_req_seq;
  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int NW    = 8;
  localparam int GAP   = 5;
  localparam int PULSE = 1;
  localparam int TMO   = 4096;
  localparam int TW    = 3 + AW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  eeprom_req_seq_if #(.AW(AW), .DW(DW), .NW(NW)) bus_if ();

  eeprom_req_seq #(.AW(AW), .DW(DW), .NW(NW), .GAP(GAP), .PULSE(PULSE), .TMO(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bridge model: memory plus programmable ack latency, drop, hold and corruption
  bit [DW-1:0]   mem     [0:(1<<AW)-1];
  bit [DW-1:0]   ref_mem [0:(1<<AW)-1];
  int            br_lat = 4, br_drop = 0, br_idx = 0, br_hold = 0, br_hold_dly = 20;
  bit            br_cor_en = 1'b0;
  logic [AW-1:0] br_cor_addr = '0;
  bit            pend = 1'b0;
  int            pend_cnt = 0;
  logic          pend_rd;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d;
  logic          br_wr_p = 1'b0, br_rd_p = 1'b0;

  initial begin
    bus_if.ack     = 1'b0;
    bus_if.data_in = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus_if.ack = 1'b0;
        pend = 1'b0;
        br_wr_p = 1'b0;
        br_rd_p = 1'b0;
      end else begin
        if (bus_if.ack && br_hold == 0) bus_if.ack = 1'b0;
        if ((bus_if.wr && !br_wr_p) || (bus_if.rd && !br_rd_p)) begin
          br_idx++;
          if (br_idx != br_drop) begin
            pend     = 1'b1;
            pend_cnt = (br_hold != 0 && bus_if.ack) ? br_hold_dly : br_lat;
            pend_rd  = bus_if.rd;
            pend_a   = bus_if.addr;
            pend_d   = bus_if.data_out;
          end
        end else if (pend) begin
          if (pend_cnt > 0) pend_cnt--;
          else if (bus_if.ack) bus_if.ack = 1'b0;
          else begin
            if (pend_rd)
              bus_if.data_in = mem[pend_a] ^ ((br_cor_en && pend_a == br_cor_addr) ? DW'(1) : DW'(0));
            else
              mem[pend_a] = pend_d;
            bus_if.ack = 1'b1;
            pend = 1'b0;
          end
        end
        br_wr_p = bus_if.wr;
        br_rd_p = bus_if.rd;
      end
    end
  end

  // monitor: request starts and done pulses
  logic [TW-1:0] obs_q[$];
  int            req_cyc[$];
  int            done_n = 0, done_cyc = 0;
  logic          done_busy = 1'b0;
  logic          mon_wr_p = 1'b0, mon_rd_p = 1'b0;

  initial forever begin
    @(negedge clk);
    if ((bus_if.wr && !mon_wr_p) || (bus_if.rd && !mon_rd_p)) begin
      obs_q.push_back({bus_if.rd, bus_if.wr, bus_if.data_oe, bus_if.addr,
                       (bus_if.wr ? bus_if.data_out : {DW{1'b0}})});
      req_cyc.push_back(cyc);
    end
    if (bus_if.done) begin
      done_n++;
      done_cyc  = cyc;
      done_busy = bus_if.busy;
    end
    mon_wr_p = bus_if.wr;
    mon_rd_p = bus_if.rd;
  end

  // reference: expected request list and readback result for one sequence
  logic [TW-1:0] exp_q[$];
  int            exp_err;
  logic [AW-1:0] exp_eaddr;
  bit            exp_to;

  task automatic build_expect(input int m, input logic [AW-1:0] b, input int n, input logic [DW-1:0] s);
    int idx;
    logic [AW-1:0] a;
    logic [DW-1:0] pat, got;
    idx = 0;
    exp_q.delete();
    exp_err = 0;
    exp_eaddr = '0;
    exp_to = 1'b0;
    if (m == 3) m = 0;
    if (m != 1) begin
      for (int k = 0; k < n; k++) begin
        a   = AW'((int'(b) + k) % (1 << AW));
        pat = DW'(int'(a) % (1 << DW)) ^ s;
        idx++;
        exp_q.push_back({1'b0, 1'b1, 1'b1, a, pat});
        if (idx == br_drop) begin exp_to = 1'b1; return; end
        ref_mem[a] = pat;
      end
    end
    if (m != 0) begin
      for (int k = 0; k < n; k++) begin
        a   = AW'((int'(b) + k) % (1 << AW));
        pat = DW'(int'(a) % (1 << DW)) ^ s;
        idx++;
        exp_q.push_back({1'b1, 1'b0, 1'b0, a, {DW{1'b0}}});
        if (idx == br_drop) begin exp_to = 1'b1; return; end
        got = ref_mem[a] ^ ((br_cor_en && a == br_cor_addr) ? DW'(1) : DW'(0));
        if (got != pat) begin
          if (exp_err == 0) exp_eaddr = a;
          if (exp_err < (1 << NW) - 1) exp_err++;
        end
      end
    end
  endtask

  function automatic logic [63:0] outs_pack();
    return 64'({bus_if.wr, bus_if.rd, bus_if.addr, bus_if.data_out, bus_if.data_oe, bus_if.busy,
                bus_if.done, bus_if.timeout, bus_if.err_cnt, bus_if.err_addr});
  endfunction

  int start_cyc = 0;

  task automatic clear_mon();
    obs_q.delete();
    req_cyc.delete();
    done_n = 0;
    br_idx = 0;
  endtask

  task automatic run_seq(input int m, input logic [AW-1:0] b, input int n, input logic [DW-1:0] s, input bit poke);
    @(negedge clk);
    clear_mon();
    bus_if.mode      = 2'(m);
    bus_if.base_addr = b;
    bus_if.num       = NW'(n);
    bus_if.seed      = s;
    bus_if.start     = 1'b1;
    start_cyc        = cyc;
    @(negedge clk);
    bus_if.start = 1'b0;
    if (poke) begin
      for (int i = 0; i < 2000 && obs_q.size() == 0; i++) @(negedge clk);
      bus_if.mode = 2'd1; bus_if.num = '0; bus_if.base_addr = AW'(11'h555); bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
    end
    for (int i = 0; i < 20000 && done_n == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_seq(input string t);
    chk({t, "_nreq"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_req%0d", t, i), obs_q[i], exp_q[i]);
    chk({t, "_done_n"}, done_n, 1);
    chk({t, "_done_busy"}, done_busy, 0);
    chk({t, "_busy"}, bus_if.busy, 0);
    chk({t, "_oe"}, bus_if.data_oe, 0);
    chk({t, "_timeout"}, bus_if.timeout, exp_to);
    chk({t, "_err_cnt"}, bus_if.err_cnt, exp_err);
    chk({t, "_err_addr"}, bus_if.err_addr, exp_eaddr);
  endtask

  initial begin
    int m, n;
    logic [AW-1:0] b;
    logic [DW-1:0] s;
    bus_if.start = 1'b0; bus_if.mode = '0; bus_if.base_addr = '0; bus_if.num = '0; bus_if.seed = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs_pack(), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 16-byte write burst, slow bridge
    br_lat = 20;
    build_expect(0, 11'h000, 16, 8'hA5);
    run_seq(0, 11'h000, 16, 8'hA5, 1'b0);
    check_seq("t1");

    // write then read across the address wrap
    br_lat = 6;
    build_expect(2, 11'h7FE, 4, 8'h3C);
    run_seq(2, 11'h7FE, 4, 8'h3C, 1'b0);
    check_seq("t2");

    // same with one corrupted readback byte
    br_cor_en = 1'b1; br_cor_addr = 11'h7FF;
    build_expect(2, 11'h7FE, 4, 8'h3C);
    run_seq(2, 11'h7FE, 4, 8'h3C, 1'b0);
    check_seq("t3");
    br_cor_en = 1'b0;

    // second request never acknowledged
    br_drop = 2;
    build_expect(0, 11'h100, 3, 8'h5A);
    run_seq(0, 11'h100, 3, 8'h5A, 1'b0);
    check_seq("t4");
    chk("t4_tmo_delay", (req_cyc.size() >= 2) && ((done_cyc - req_cyc[1]) inside {[TMO:TMO+4]}), 1);
    br_drop = 0;

    // empty burst
    build_expect(1, 11'h010, 0, 8'h00);
    run_seq(1, 11'h010, 0, 8'h00, 1'b0);
    check_seq("t5a");
    chk("t5a_done_lat", done_cyc - start_cyc, 2);

    // start while busy is ignored
    build_expect(0, 11'h020, 3, 8'h11);
    run_seq(0, 11'h020, 3, 8'h11, 1'b1);
    check_seq("t5b");

    // ack held high: second transfer needs a fresh rising edge
    br_hold = 1; br_lat = 3; br_hold_dly = 20;
    build_expect(0, 11'h040, 2, 8'h77);
    run_seq(0, 11'h040, 2, 8'h77, 1'b0);
    check_seq("t5c");
    chk("t5c_hold_wait", (req_cyc.size() >= 2) && ((done_cyc - req_cyc[1]) >= 20), 1);
    br_hold = 0;
    repeat (3) @(negedge clk);

    // reset in the middle of a wait, then a clean rerun
    br_lat = 15;
    @(negedge clk);
    clear_mon();
    bus_if.mode = 2'd2; bus_if.base_addr = 11'h300; bus_if.num = NW'(4); bus_if.seed = 8'h99;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int i = 0; i < 2000 && obs_q.size() == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_outs", outs_pack(), 64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_no_done", done_n, 0);
    build_expect(2, 11'h300, 4, 8'h99);
    run_seq(2, 11'h300, 4, 8'h99, 1'b0);
    check_seq("t6");

    // randomized bursts
    for (int r = 0; r < 6; r++) begin
      m = int'($urandom_range(0, 3));
      b = AW'($urandom);
      n = int'($urandom_range(1, 10));
      s = DW'($urandom);
      br_lat = int'($urandom_range(1, 8));
      br_cor_en = 1'($urandom_range(0, 1));
      br_cor_addr = AW'(int'(b) + int'($urandom_range(0, n - 1)));
      build_expect(m, b, n, s);
      run_seq(m, b, n, s, 1'b0);
      check_seq($sformatf("rnd%0d", r));
    end
    br_cor_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
